// File: rtl/sys1_video_pkg.sv
// Shared types and field widths for the System 1 sprite/scanline video path.
package sys1_video_pkg;

  localparam int unsigned LBW   = 11;  // line-buffer word {pal, pix}
  localparam int unsigned PIX_W = 4;
  localparam int unsigned PAL_W = 7;
  localparam int unsigned XW    = 10;  // line-buffer address width
  localparam int unsigned NB_W  = 6;   // byte count width

  localparam logic [PIX_W-1:0] PIX_TRANSPARENT = 4'h0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_RDH,
    S_WRH,
    S_RDL,
    S_WRL,
    S_DONE
  } slw_state_e;

endpackage

// File: rtl/sprite_line_writer.sv
// Sprite row writer: fetches 4bpp bytes from the sprite ROM and merges the
// pixels into the scanline buffer with read-modify-write, honouring
// transparency and first-drawn-wins priority.
module sprite_line_writer #(
  parameter int unsigned RAW = 16,
  parameter int unsigned LBW = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [9:0]     xpos,
  input  logic [RAW-1:0] romadr,
  input  logic [5:0]     nbytes,
  input  logic [6:0]     pal,
  input  logic           hflip,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           coll,
  output logic [RAW-1:0] rom_adr,
  input  logic [7:0]     rom_dat,
  output logic [9:0]     lb_wadr,
  output logic [LBW-1:0] lb_wdat,
  output logic           lb_we,
  input  logic [LBW-1:0] lb_rdat
);
  import sys1_video_pkg::*;

  slw_state_e     state_q, state_d;
  logic [9:0]     x_q, x_d;
  logic [RAW-1:0] adr_q, adr_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [6:0]     pal_q, pal_d;
  logic           hflip_q, hflip_d;
  logic [7:0]     byte_q, byte_d;
  logic           coll_q, coll_d;

  logic [PIX_W-1:0] pix;
  logic             occupied;
  logic [9:0]       x_step;

  assign pix      = (state_q == S_WRH) ? byte_q[7:4] : byte_q[3:0];
  assign occupied = (lb_rdat[PIX_W-1:0] != PIX_TRANSPARENT);
  assign x_step   = hflip_q ? (x_q - 10'd1) : (x_q + 10'd1);

  // State and request-field registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      adr_q   <= '0;
      cnt_q   <= '0;
      pal_q   <= '0;
      hflip_q <= 1'b0;
      byte_q  <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      pal_q   <= pal_d;
      hflip_q <= hflip_d;
      byte_q  <= byte_d;
      coll_q  <= coll_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    pal_d   = pal_q;
    hflip_d = hflip_q;
    byte_d  = byte_q;
    coll_d  = coll_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = xpos;
          adr_d   = romadr;
          cnt_d   = nbytes;
          pal_d   = pal;
          hflip_d = hflip;
          coll_d  = 1'b0;
          state_d = (nbytes == 6'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        byte_d  = rom_dat;
        state_d = S_RDH;
      end
      S_RDH: state_d = S_WRH;
      S_WRH: begin
        if (pix != PIX_TRANSPARENT && occupied) coll_d = 1'b1;
        x_d     = x_step;
        state_d = S_RDL;
      end
      S_RDL: state_d = S_WRL;
      S_WRL: begin
        if (pix != PIX_TRANSPARENT && occupied) coll_d = 1'b1;
        x_d     = x_step;
        cnt_d   = cnt_q - 6'd1;
        adr_d   = adr_q + RAW'(1);
        state_d = (cnt_q == 6'd1) ? S_DONE : S_FETCH;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Output decode; only lb_we looks at inputs (readback and abort)
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    coll    = 1'b0;
    rom_adr = '0;
    lb_wadr = '0;
    lb_wdat = '0;
    lb_we   = 1'b0;
    unique case (state_q)
      S_FETCH: rom_adr = adr_q;
      S_RDH, S_RDL: lb_wadr = x_q;
      S_WRH, S_WRL: begin
        lb_wadr = x_q;
        lb_wdat = {pal_q, pix};
        lb_we   = !abort && (pix != PIX_TRANSPARENT) && !occupied;
      end
      S_DONE: begin
        done = 1'b1;
        coll = coll_q;
      end
      default: ;
    endcase
  end

endmodule
